// File: rtl/fetch_queue_pkg.sv
// Shared types and helpers for the instruction prefetch queue.
package fq_pkg;

    localparam int FQ_XLEN = 32;

    typedef struct packed {
        logic [FQ_XLEN-1:0] instr;
        logic [FQ_XLEN-1:0] pcnext;
    } fq_entry_t;

    // Pointer width for a power-of-two depth (ceil(log2(n))).
    function automatic int fq_ptr_w(input int n);
        int w;
        w = 32'sd0;
        while ((32'sd1 << w) < n) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the instruction-memory, redirect and IF_ID handshake signals.
interface fetch_queue_if
    import fq_pkg::*;
#(
    parameter int XLEN  = FQ_XLEN,
    parameter int DEPTH = 4
);
    logic                     imem_req;
    logic [XLEN-1:0]          imem_addr;
    logic [XLEN-1:0]          imem_rdata;
    logic                     redirect_valid;
    logic [XLEN-1:0]          redirect_pc;
    logic                     deq_valid;
    logic                     deq_ready;
    logic [XLEN-1:0]          deq_instr;
    logic [XLEN-1:0]          deq_pcnext;
    logic [fq_ptr_w(DEPTH):0] fq_count;

    modport master (
        output imem_req, imem_addr, deq_valid, deq_instr, deq_pcnext, fq_count,
        input  imem_rdata, redirect_valid, redirect_pc, deq_ready
    );

    modport slave (
        input  imem_req, imem_addr, deq_valid, deq_instr, deq_pcnext, fq_count,
        output imem_rdata, redirect_valid, redirect_pc, deq_ready
    );
endinterface

// File: rtl/fetch_queue_fifo.sv
// Generic DEPTH x WIDTH circular buffer; flush outranks push and pop.
module fetch_fifo
    import fq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2 * FQ_XLEN
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [fq_ptr_w(DEPTH):0] o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int            PW       = fq_ptr_w(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == {(PW + 1){1'b0}});
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_rd_ptr <= {PW{1'b0}};
            r_wr_ptr <= {PW{1'b0}};
            r_count  <= {(PW + 1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PW + 1)'(1);
                2'b01:   r_count <= r_count - (PW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (w_do_push && !reset && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch unit: sequential fetch, response buffering, redirect flush.
module fetch_queue
    import fq_pkg::*;
#(
    parameter int              XLEN     = FQ_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter logic [XLEN-1:0] PC_STEP  = {{(XLEN - 1){1'b0}}, 1'b1}
) (
    input logic           clk,
    input logic           reset,
    fetch_queue_if.master bus
);
    localparam int          CW        = fq_ptr_w(DEPTH);
    localparam logic [CW:0] DEPTH_CNT = (CW + 1)'(DEPTH);

    logic [XLEN-1:0]   r_fetch_pc;
    logic [XLEN-1:0]   r_req_pc;
    logic              r_inflight;
    logic              r_kill;
    logic [CW:0]       w_count;
    logic [CW:0]       w_occ;
    logic              w_full;
    logic              w_empty;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic [2*XLEN-1:0] w_wdata;
    logic [2*XLEN-1:0] w_rdata;

    // Reserve a slot for the outstanding response so the queue can never overflow.
    assign w_occ   = w_count + {{CW{1'b0}}, r_inflight};
    assign w_issue = !reset && !bus.redirect_valid && !w_full && (w_occ < DEPTH_CNT);
    assign w_push  = r_inflight && !r_kill && !bus.redirect_valid;
    assign w_pop   = bus.deq_ready && !bus.redirect_valid;
    assign w_wdata = {bus.imem_rdata, r_req_pc + PC_STEP};

    assign bus.imem_req   = w_issue;
    assign bus.imem_addr  = r_fetch_pc;
    assign bus.deq_valid  = !w_empty;
    assign bus.deq_instr  = w_rdata[2*XLEN-1:XLEN];
    assign bus.deq_pcnext = w_rdata[XLEN-1:0];
    assign bus.fq_count   = w_count;

    // Fetch PC, outstanding-request tracking and redirect kill window.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= {XLEN{1'b0}};
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_fetch_pc <= bus.redirect_pc;
            r_inflight <= 1'b0;
            r_kill     <= 1'b1;
        end else begin
            r_kill     <= 1'b0;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + PC_STEP;
                r_req_pc   <= r_fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_valid),
        .o_rdata (w_rdata),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: model of fetch order plus directed timing checks.
module tb_fetch_queue;
    import fq_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    fetch_queue_if #(.XLEN(32), .DEPTH(DEPTH)) bus_if ();

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_STEP(32'h1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: data = address + 0x100, one cycle later.
    always @(posedge clk) begin
        bus_if.imem_rdata <= bus_if.imem_addr + 32'h0000_0100;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Scoreboard: predicted queue contents and the expected fetch stream.
    fq_entry_t   sb_q[$];
    fq_entry_t   pend_e;
    fq_entry_t   got_e;
    bit          pend_v   = 1'b0;
    logic [31:0] model_pc = RESET_PC;

    always @(negedge clk) begin
        if (n_checks >= 0) begin
            if (reset) begin
                check_eq("req_in_reset", 64'(bus_if.imem_req), 64'd0);
                sb_q.delete();
                pend_v   = 1'b0;
                model_pc = RESET_PC;
            end else begin
                check_eq("fq_count", 64'(bus_if.fq_count), 64'(sb_q.size()));
                check_eq("deq_valid", 64'(bus_if.deq_valid), 64'(sb_q.size() != 0));
                check_eq("count_bound", 64'(bus_if.fq_count <= DEPTH), 64'd1);
                if (bus_if.redirect_valid) begin
                    check_eq("req_in_redirect", 64'(bus_if.imem_req), 64'd0);
                    sb_q.delete();
                    pend_v   = 1'b0;
                    model_pc = bus_if.redirect_pc;
                end else begin
                    check_eq("issue_gate", 64'(bus_if.imem_req),
                             64'((sb_q.size() + int'(pend_v)) < DEPTH));
                    if (bus_if.deq_valid && bus_if.deq_ready && sb_q.size() != 0) begin
                        got_e = sb_q.pop_front();
                        check_eq("deq_instr", 64'(bus_if.deq_instr), 64'(got_e.instr));
                        check_eq("deq_pcnext", 64'(bus_if.deq_pcnext), 64'(got_e.pcnext));
                    end
                    if (pend_v) begin
                        sb_q.push_back(pend_e);
                        pend_v = 1'b0;
                    end
                    if (bus_if.imem_req) begin
                        check_eq("imem_addr", 64'(bus_if.imem_addr), 64'(model_pc));
                        pend_e.instr  = model_pc + 32'h0000_0100;
                        pend_e.pcnext = model_pc + 32'h0000_0001;
                        pend_v        = 1'b1;
                        model_pc      = model_pc + 32'h0000_0001;
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_req;
        n_checks                 = 0;
        n_errors                 = 0;
        reset                    = 1'b1;
        bus_if.deq_ready         = 1'b1;
        bus_if.redirect_valid    = 1'b0;
        bus_if.redirect_pc       = 32'h0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_eq("rst_count", 64'(bus_if.fq_count), 64'd0);
        check_eq("rst_deq_valid", 64'(bus_if.deq_valid), 64'd0);

        // Fill latency and streaming with deq_ready held high.
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check_eq("t1_req0", 64'(bus_if.imem_req), 64'd1);
        check_eq("t1_addr0", 64'(bus_if.imem_addr), 64'(RESET_PC));
        next_cycle();
        @(negedge clk);
        check_eq("t1_valid_c1", 64'(bus_if.deq_valid), 64'd0);
        next_cycle();
        @(negedge clk);
        check_eq("t1_valid_c2", 64'(bus_if.deq_valid), 64'd1);
        check_eq("t1_head_instr", 64'(bus_if.deq_instr), 64'h100);
        check_eq("t1_head_pcnext", 64'(bus_if.deq_pcnext), 64'h1);
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            @(negedge clk);
            check_eq("t1_stream_req", 64'(bus_if.imem_req), 64'd1);
            check_eq("t1_stream_valid", 64'(bus_if.deq_valid), 64'd1);
        end

        // Stall from reset: exactly DEPTH requests, then resume.
        next_cycle();
        reset            = 1'b1;
        bus_if.deq_ready = 1'b0;
        next_cycle();
        reset = 1'b0;
        n_req = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus_if.imem_req) n_req = n_req + 1;
            next_cycle();
        end
        check_eq("t2_num_req", 64'(n_req), 64'd4);
        @(negedge clk);
        check_eq("t2_full_count", 64'(bus_if.fq_count), 64'd4);
        check_eq("t2_full_noreq", 64'(bus_if.imem_req), 64'd0);
        next_cycle();
        bus_if.deq_ready = 1'b1;
        @(negedge clk);
        check_eq("t2_first_head", 64'(bus_if.deq_instr), 64'h100);
        next_cycle();
        @(negedge clk);
        check_eq("t2_resume_req", 64'(bus_if.imem_req), 64'd1);
        check_eq("t2_resume_addr", 64'(bus_if.imem_addr), 64'h4);
        repeat (6) next_cycle();

        // Redirect with count=3 and one response in flight.
        reset            = 1'b1;
        bus_if.deq_ready = 1'b0;
        next_cycle();
        reset = 1'b0;
        repeat (4) next_cycle();
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h40;
        @(negedge clk);
        check_eq("t3_count_before", 64'(bus_if.fq_count), 64'd3);
        next_cycle();
        bus_if.redirect_valid = 1'b0;
        bus_if.deq_ready      = 1'b1;
        @(negedge clk);
        check_eq("t3_flushed", 64'(bus_if.fq_count), 64'd0);
        check_eq("t3_req", 64'(bus_if.imem_req), 64'd1);
        check_eq("t3_addr", 64'(bus_if.imem_addr), 64'h40);
        next_cycle();
        @(negedge clk);
        check_eq("t3_valid_t2", 64'(bus_if.deq_valid), 64'd0);
        next_cycle();
        @(negedge clk);
        check_eq("t3_valid_t3", 64'(bus_if.deq_valid), 64'd1);
        check_eq("t3_instr", 64'(bus_if.deq_instr), 64'h140);
        check_eq("t3_pcnext", 64'(bus_if.deq_pcnext), 64'h41);
        repeat (4) next_cycle();

        // Back-to-back redirects: the second wins.
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'h10;
        next_cycle();
        bus_if.redirect_pc = 32'h20;
        next_cycle();
        bus_if.redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("t4_addr", 64'(bus_if.imem_addr), 64'h20);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_eq("t4_head", 64'(bus_if.deq_instr), 64'h120);
        check_eq("t4_pcnext", 64'(bus_if.deq_pcnext), 64'h21);
        repeat (4) next_cycle();

        // PC wrap at the top of the address space.
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 32'hFFFF_FFFF;
        next_cycle();
        bus_if.redirect_valid = 1'b0;
        @(negedge clk);
        check_eq("t5_addr_top", 64'(bus_if.imem_addr), 64'hFFFF_FFFF);
        next_cycle();
        @(negedge clk);
        check_eq("t5_addr_wrap", 64'(bus_if.imem_addr), 64'h0);
        next_cycle();
        @(negedge clk);
        check_eq("t5_instr_top", 64'(bus_if.deq_instr), 64'hFF);
        check_eq("t5_pcnext_wrap", 64'(bus_if.deq_pcnext), 64'h0);
        next_cycle();
        @(negedge clk);
        check_eq("t5_instr_next", 64'(bus_if.deq_instr), 64'h100);
        check_eq("t5_pcnext_next", 64'(bus_if.deq_pcnext), 64'h1);

        // Reset while full, then reset with a response in flight.
        next_cycle();
        bus_if.deq_ready = 1'b0;
        repeat (8) next_cycle();
        @(negedge clk);
        check_eq("t6_full", 64'(bus_if.fq_count), 64'd4);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check_eq("t6_count", 64'(bus_if.fq_count), 64'd0);
        check_eq("t6_valid", 64'(bus_if.deq_valid), 64'd0);
        check_eq("t6_addr", 64'(bus_if.imem_addr), 64'(RESET_PC));
        check_eq("t6_req", 64'(bus_if.imem_req), 64'd1);
        repeat (4) next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check_eq("t6b_count_r0", 64'(bus_if.fq_count), 64'd0);
        next_cycle();
        @(negedge clk);
        check_eq("t6b_stale_dropped", 64'(bus_if.fq_count), 64'd0);
        bus_if.deq_ready = 1'b1;
        repeat (8) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
